// File: rtl/reg_arbiter.sv
// reg_arbiter: two-requester arbiter in front of a 4 x 8-bit register bank (IDLE/ACCESS/DONE).
// Optional round-robin arbitration on contention is enabled by defining REG_ARBITER_RR_EN.
`default_nettype none

module reg_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       wr0,
  input  logic       wr1,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       wr_q, wr_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] bank_q [4];
  logic [7:0] rdata_q;
  logic       pick;
`ifdef REG_ARBITER_RR_EN
  logic       last_q, last_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 2'd0;
      wdata_q <= 8'h00;
`ifdef REG_ARBITER_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef REG_ARBITER_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pick    = 1'b0;
`ifdef REG_ARBITER_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
`ifdef REG_ARBITER_RR_EN
          // On contention the requester not served last wins.
          pick   = (req0 && req1) ? ~last_q : req1;
          last_d = pick;
`else
          pick   = ~req0;
`endif
          gnt_d   = pick;
          wr_d    = pick ? wr1 : wr0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        bank_q[i] <= 8'h00;
      end
      rdata_q <= 8'h00;
    end else if (state_q == S_ACCESS) begin
      if (wr_q) begin
        bank_q[addr_q] <= wdata_q;
      end else begin
        rdata_q <= bank_q[addr_q];
      end
    end
  end

  assign ack0  = (state_q == S_DONE) && !gnt_q;
  assign ack1  = (state_q == S_DONE) &&  gnt_q;
  assign busy  = (state_q != S_IDLE);
  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_arbiter.sv
// Scoreboard bench for reg_arbiter: a transaction-level model predicts the winner and read data per grant.
`default_nettype none

module tb_reg_arbiter;

  logic       clk;
  logic       reset;
  logic       req   [2];
  logic       wr    [2];
  logic [1:0] addr  [2];
  logic [7:0] wdata [2];
  wire        ack0, ack1, busy;
  wire  [7:0] rdata;
  wire  [1:0] ackv;

  assign ackv = {ack1, ack0};

  reg_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .req1(req[1]), .wr0(wr[0]), .wr1(wr[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: one entry per grant, cycles remaining until the arbiter samples again.
  typedef struct { bit who; logic [7:0] rd; } exp_t;
  exp_t       sb [$];
  logic [7:0] mem [4];
  logic [7:0] m_rdata;
  int         cool;
  bit         last;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
      m_rdata = 8'h00;
      cool    = 0;
      last    = 1'b1;
      sb.delete();
    end else if (cool != 0) begin
      cool--;
    end else if (req[0] || req[1]) begin
      bit w;
      exp_t e;
      if (req[0] && req[1]) begin
`ifdef REG_ARBITER_RR_EN
        w = ~last;
`else
        w = 1'b0;
`endif
      end else begin
        w = req[1];
      end
      last = w;
      if (wr[w]) mem[addr[w]] = wdata[w];
      else       m_rdata = mem[addr[w]];
      e.who = w;
      e.rd  = m_rdata;
      sb.push_back(e);
      cool = 2;
    end
  end

  // Monitor: compare whenever the DUT presents an ack.
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", busy, int'(cool != 0));
      chk("ack_onehot", int'(ack0 & ack1), 0);
      chk("ack_timing", int'(ack0 | ack1), int'(cool == 1));
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          note_fail("ack_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_who", ack1, e.who);
          chk("rdata", rdata, e.rd);
        end
      end
    end
  end

  task automatic do_access(input int who, input bit w, input logic [1:0] a,
                           input logic [7:0] d, input bit scramble);
    bit got;
    got = 1'b0;
    @(negedge clk);
    req[who] = 1'b1; wr[who] = w; addr[who] = a; wdata[who] = d;
    if (scramble) begin
      @(posedge clk);
      #1 wdata[who] = 8'hFF;
    end
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (ackv[who]) got = 1'b1;
    end
    req[who] = 1'b0;
    if (!got) note_fail("ack_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hold [2];
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 2'd0; wdata[i] = 8'h00; hold[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ack", int'(ackv), 0);
    chk("reset_rdata", rdata, 0);
    reset = 1'b0;

    // Reads of a freshly reset bank, then write/read, then input change after latch.
    for (int a = 0; a < 4; a++) do_access(1, 1'b0, 2'(a), 8'h00, 1'b0);
    do_access(0, 1'b1, 2'd2, 8'hA5, 1'b0);
    do_access(0, 1'b0, 2'd2, 8'h00, 1'b0);
    do_access(0, 1'b1, 2'd3, 8'h3C, 1'b1);
    do_access(1, 1'b0, 2'd3, 8'h00, 1'b0);
    do_access(0, 1'b1, 2'd0, 8'h11, 1'b0);
    do_access(1, 1'b1, 2'd0, 8'h22, 1'b0);
    do_access(0, 1'b0, 2'd0, 8'h00, 1'b0);

    // Randomized two-requester traffic following the hold-until-ack protocol.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && ackv[i]) begin
          req[i] = 1'b0; hold[i] = 0;
        end else if (req[i]) begin
          hold[i]++;
          if (hold[i] > 90) begin
            note_fail("grant_timeout", hold[i], 90);
            req[i] = 1'b0; hold[i] = 0;
          end
        end else if ($urandom_range(1, 0) == 1) begin
          req[i]   = 1'b1;
          wr[i]    = 1'($urandom_range(1, 0));
          addr[i]  = 2'($urandom_range(3, 0));
          wdata[i] = 8'($urandom);
        end
        if ($urandom_range(3, 0) == 0) wdata[i] = 8'($urandom);
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of a write's ACCESS cycle.
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 2'd1; wdata[0] = 8'h77;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_ack", int'(ackv), 0);
    chk("midreset_rdata", rdata, 0);
    req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_access(0, 1'b0, 2'd1, 8'h00, 1'b0);

    // Both requesters held continuously from a fresh reset.
    pulse_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b1; wr[i] = 1'b0; addr[i] = 2'(i + 1);
    end
    repeat (18) @(negedge clk);
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (6) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameters: none; data width fixed at 8, bank depth fixed at 4.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0 / req1  input  1  access request from requester 0 / 1.
REQ-005 wr0 / wr1  input  1  1 = write, 0 = read.
REQ-006 addr0 / addr1  input  2  register index 0..3.
REQ-007 wdata0 / wdata1  input  8  write data.
REQ-008 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-009 rdata  output  8  registered read data, shared by both requesters.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 The block SHALL contain a bank of four 8-bit registers, accessible only through this arbiter.
REQ-012 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-013 IDLE: on a clock edge with any req high, the block SHALL grant one requester, latch its wr/addr/wdata, and go to ACCESS. With no req high it SHALL stay in IDLE.
REQ-014 ACCESS: on the next edge the block SHALL perform the access and go to DONE. A write sets bank[addr] <= wdata. A read sets rdata <= bank[addr].
REQ-015 DONE: ack of the granted requester SHALL be high for exactly this one cycle. The next edge SHALL clear ack and return to IDLE.
REQ-016 Latency: req sampled at edge k gives ack high from edge k+1 to edge k+2. The earliest next grant is at edge k+3, so throughput is one access per 3 cycles.
REQ-017 Req is not sampled in ACCESS or DONE. A requester SHALL hold req until it sees ack and drop it in the following cycle. A req still high in IDLE is a new request.
REQ-018 Input changes after the latch edge SHALL NOT affect the transaction in progress.
REQ-019 Arbitration with a single req high SHALL grant that requester. Behaviour with both req high is set in Configuration.
REQ-020 rdata SHALL change only on a read access. It holds its value across writes and idle cycles.
REQ-021 A write followed by a read of the same index SHALL return the written value.
REQ-022 At most one of ack0/ack1 SHALL be high in any cycle, and never outside DONE.

Reset
REQ-023 Asserting reset SHALL force, without waiting for clk: state = IDLE, all bank registers = 8'h00, rdata = 8'h00, ack0 = ack1 = 0, busy = 0, last-grant pointer = 1.
REQ-024 Reset during ACCESS or DONE SHALL abort the transaction. No write occurs unless the ACCESS edge has already passed, and no ack is issued.
REQ-025 The first grant after reset release SHALL follow REQ-013 and occurs no earlier than the first clk edge with reset low.

Configuration
REQ-026 Macro REG_ARBITER_RR_EN defined: when both req are high in IDLE, the block SHALL grant the requester that was not granted last, then update the last-grant pointer.
REQ-027 REG_ARBITER_RR_EN undefined: requester 0 SHALL always win when both req are high. The pointer is not used.

Verification
REQ-028 Reset, then req0 write addr 2 = 8'hA5, then req0 read addr 2 -> ack0 at edge k+1 for each access; rdata = 8'hA5; ack1 never high.
REQ-029 req0 and req1 both held high continuously, with RR_EN defined -> grants alternate 0,1,0,1 (first grant 0). With RR_EN undefined -> requester 0 is always granted.
REQ-030 req1 reads each of addr 0..3 after reset -> rdata = 8'h00 each time; busy high for exactly 2 cycles per access.
REQ-031 req0 write of 8'h3C latched, then wdata0 changed to 8'hFF during ACCESS -> bank holds 8'h3C.
REQ-032 Reset asserted mid-cycle during ACCESS of a write of 8'h77 to addr 1 -> outputs clear immediately; no ack; a subsequent read of addr 1 returns 8'h00.
REQ-033 Back-to-back: req0 dropped one cycle after ack0 while req1 is already high -> req1 is granted at the first IDLE edge; ack1 arrives 3 cycles after ack0.
